irq_source_unit: RTL and testbench



---
 rtl/irq_source_unit_pkg.sv | 17 +
 rtl/irq_sync2.sv | 13 +
 rtl/irq_source_unit.sv | 112 +++++++++++
 tb/tb_irq_source_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_source_unit_pkg.sv
// irq_source_unit_pkg: bus offsets, interrupt cause codes and FSM encoding shared by the interrupt source block.
package irq_source_unit_pkg;
  localparam logic [4:0] ADDR_MSIP    = 5'h00;
  localparam logic [4:0] ADDR_CMP_LO  = 5'h04;
  localparam logic [4:0] ADDR_CMP_HI  = 5'h08;
  localparam logic [4:0] ADDR_TIME_LO = 5'h0C;
  localparam logic [4:0] ADDR_TIME_HI = 5'h10;
  localparam logic [30:0] CODE_MSI = 31'd3;
  localparam logic [30:0] CODE_MTI = 31'd7;
  localparam logic [30:0] CODE_MEI = 31'd11;
  localparam logic IRQ_BIT = 1'b1;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;
endpackage

// File: rtl/irq_sync2.sv
// irq_sync2: two-flop synchroniser for an asynchronous level input.
module irq_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_s <= '0;
    else      r_s <= {r_s[0], i_d};
  assign o_q = r_s[1];
endmodule

// File: rtl/irq_source_unit.sv
// irq_source_unit: msip/mtime/mtimecmp registers plus a prioritised, cause-tagged
// machine interrupt request tracked through acknowledge and mret.
module irq_source_unit
  import irq_source_unit_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  bus_addr,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic        ext_irq,
  input  logic        mie_global,
  input  logic [2:0]  mie_mask,
  output logic        interrupt,
  output logic [31:0] irq_cause,
  input  logic        irq_ack,
  input  logic        mret
);
  logic        r_msip;
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [15:0] r_presc;
  state_t      r_state;
  logic        w_meip;
  logic        w_tick;
  logic        w_wr_tlo;
  logic        w_wr_thi;
  logic        w_eligible;
  logic [2:0]  w_pend;
  logic [31:0] w_cause;
  logic [31:0] w_rd;

  irq_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (ext_irq),
    .o_q (w_meip)
  );

  assign w_tick     = r_presc == 16'(TICK_DIV - 1);
  assign w_wr_tlo   = bus_we && bus_addr == ADDR_TIME_LO;
  assign w_wr_thi   = bus_we && bus_addr == ADDR_TIME_HI;
  assign w_pend     = {w_meip, r_mtime >= r_mtimecmp, r_msip} & mie_mask;
  assign w_eligible = mie_global && |w_pend;
  // Priority external > software > timer, regardless of bit order in the mask.
  assign w_cause = w_pend[2] ? {IRQ_BIT, CODE_MEI} :
                   w_pend[0] ? {IRQ_BIT, CODE_MSI} : {IRQ_BIT, CODE_MTI};
  assign w_rd = bus_addr == ADDR_MSIP    ? {31'b0, r_msip}    :
                bus_addr == ADDR_CMP_LO  ? r_mtimecmp[31:0]  :
                bus_addr == ADDR_CMP_HI  ? r_mtimecmp[63:32] :
                bus_addr == ADDR_TIME_LO ? r_mtime[31:0]     :
                bus_addr == ADDR_TIME_HI ? r_mtime[63:32]    : 32'b0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_msip     <= 1'b0;
      r_mtimecmp <= '1;
      r_mtime    <= '0;
      r_presc    <= '0;
      bus_rdata  <= '0;
    end else begin
      if (bus_re) bus_rdata <= w_rd;
      if (bus_we && bus_addr == ADDR_MSIP) r_msip <= bus_wdata[0];
      if (bus_we && bus_addr == ADDR_CMP_LO) r_mtimecmp[31:0] <= bus_wdata;
      if (bus_we && bus_addr == ADDR_CMP_HI) r_mtimecmp[63:32] <= bus_wdata;
      // A software write to either mtime half beats a same-cycle increment.
      if (w_wr_tlo || w_wr_thi) begin
        if (w_wr_tlo) r_mtime[31:0] <= bus_wdata;
        if (w_wr_thi) r_mtime[63:32] <= bus_wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_mtime <= r_mtime + 64'd1;
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state   <= ST_IDLE;
      interrupt <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (r_state)
        ST_IDLE:
          if (w_eligible) begin
            r_state   <= ST_REQ;
            interrupt <= 1'b1;
            irq_cause <= w_cause;
          end
        ST_REQ:
          if (irq_ack) begin
            r_state   <= ST_SERVICE;
            interrupt <= 1'b0;
          end else if (!w_eligible) begin
            r_state   <= ST_IDLE;
            interrupt <= 1'b0;
          end
        ST_SERVICE:
          if (mret) r_state <= ST_IDLE;
        default: begin
          r_state   <= ST_IDLE;
          interrupt <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_irq_source_unit.sv
// tb_irq_source_unit: directed and randomized checks of irq_source_unit against a behavioural model.
module tb_irq_source_unit;
  localparam int TD = 4;
  logic        clk = 0;
  logic        rst = 0;
  logic [4:0]  bus_addr = '0;
  logic        bus_we = 0, bus_re = 0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic        ext_irq = 0, mie_global = 0;
  logic [2:0]  mie_mask = '0;
  logic        interrupt;
  logic [31:0] irq_cause;
  logic        irq_ack = 0, mret = 0;

  int vecs = 0;
  int errs = 0;

  logic [63:0] m_time, m_cmp;
  bit          m_msip, m_int, m_svc;
  int          m_presc;
  bit [1:0]    m_sync;
  logic [31:0] m_cause, m_rd;

  always #5 clk = ~clk;

  irq_source_unit #(.TICK_DIV(TD)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_addr   (bus_addr),
    .bus_we     (bus_we),
    .bus_re     (bus_re),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .ext_irq    (ext_irq),
    .mie_global (mie_global),
    .mie_mask   (mie_mask),
    .interrupt  (interrupt),
    .irq_cause  (irq_cause),
    .irq_ack    (irq_ack),
    .mret       (mret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'h00:   return {31'b0, m_msip};
      5'h04:   return m_cmp[31:0];
      5'h08:   return m_cmp[63:32];
      5'h0C:   return m_time[31:0];
      5'h10:   return m_time[63:32];
      default: return 32'b0;
    endcase
  endfunction

  task automatic mreset();
    m_time = 0; m_cmp = '1; m_msip = 0; m_presc = 0; m_sync = 0;
    m_int = 0; m_svc = 0; m_cause = 0; m_rd = 0;
  endtask

  task automatic model_step();
    logic [2:0]  pend;
    bit          el;
    logic [31:0] c;
    if (bus_re) m_rd = mread(bus_addr);
    pend = {m_sync[1], m_time >= m_cmp, m_msip} & mie_mask;
    el = mie_global && pend != 0;
    c = pend[2] ? 32'h8000000B : pend[0] ? 32'h80000003 : 32'h80000007;
    if (m_svc) begin
      if (mret) m_svc = 0;
    end else if (m_int) begin
      if (irq_ack) begin m_int = 0; m_svc = 1; end
      else if (!el) m_int = 0;
    end else if (el) begin
      m_int = 1; m_cause = c;
    end
    if (bus_we && bus_addr == 5'h00) m_msip = bus_wdata[0];
    if (bus_we && bus_addr == 5'h04) m_cmp[31:0] = bus_wdata;
    if (bus_we && bus_addr == 5'h08) m_cmp[63:32] = bus_wdata;
    if (bus_we && (bus_addr == 5'h0C || bus_addr == 5'h10)) begin
      if (bus_addr == 5'h0C) m_time[31:0] = bus_wdata;
      else m_time[63:32] = bus_wdata;
      m_presc = 0;
    end else if (m_presc == TD - 1) begin
      m_time = m_time + 1;
      m_presc = 0;
    end else m_presc++;
    m_sync = {m_sync[0], ext_irq};
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check("interrupt", interrupt, m_int);
    check("irq_cause", irq_cause, m_cause);
    check("bus_rdata", bus_rdata, m_rd);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_we = 1;
    tick();
    bus_we = 0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] d);
    bus_addr = a; bus_re = 1;
    tick();
    bus_re = 0;
    d = bus_rdata;
  endtask

  task automatic wait_int(input bit lvl, input int maxc, input string tag);
    int n = 0;
    while (interrupt !== lvl && n < maxc) begin tick(); n++; end
    check(tag, interrupt, lvl);
  endtask

  initial begin
    logic [31:0] d;
    int n;
    mreset();
    repeat (2) @(negedge clk);
    rst = 1;
    check("rst_int", interrupt, 0);
    rd(5'h00, d); check("rst_msip", d, 0);
    rd(5'h04, d); check("rst_cmp_lo", d, 32'hFFFFFFFF);
    rd(5'h08, d); check("rst_cmp_hi", d, 32'hFFFFFFFF);
    rd(5'h0C, d); check("rst_time_lo", d, 0);
    rd(5'h10, d); check("rst_time_hi", d, 0);

    wr(5'h08, 0);
    wr(5'h04, 10);
    mie_mask = 3'b010; mie_global = 1;
    wait_int(1, 200, "timer_rise");
    check("timer_cause", irq_cause, 32'h80000007);
    irq_ack = 1; tick(); irq_ack = 0;
    check("timer_ack_fall", interrupt, 0);
    mie_mask = 0; mret = 1; tick(); mret = 0;
    wr(5'h08, 32'hFFFFFFFF);
    wr(5'h04, 32'hFFFFFFFF);

    ext_irq = 1;
    wr(5'h00, 1);
    repeat (3) tick();
    mie_mask = 3'b111;
    tick();
    check("prio_int", interrupt, 1);
    check("prio_cause", irq_cause, 32'h8000000B);

    irq_ack = 1; tick(); irq_ack = 0;
    repeat (5) begin tick(); check("svc_gate", interrupt, 0); end
    mret = 1; tick(); mret = 0;
    check("mret_idle", interrupt, 0);
    tick();
    check("mret_rereq", interrupt, 1);

    mie_global = 0; tick();
    check("withdraw", interrupt, 0);
    check("withdraw_cause", irq_cause, 32'h8000000B);
    irq_ack = 1; tick(); irq_ack = 0;
    check("ack_idle", interrupt, 0);
    mie_global = 1; tick();
    check("ack_idle_ignored", interrupt, 1);
    mie_global = 0; ext_irq = 0; tick();
    wr(5'h00, 0);

    wr(5'h10, 32'hFFFFFFFF);
    wr(5'h0C, 32'hFFFFFFFF);
    repeat (3) tick();
    rd(5'h0C, d); check("wrap_before", d, 32'hFFFFFFFF);
    rd(5'h0C, d); check("wrap_lo", d, 0);
    rd(5'h10, d); check("wrap_hi", d, 0);

    n = 0;
    while (m_presc != TD - 1 && n < 10) begin tick(); n++; end
    wr(5'h0C, 32'h1234);
    rd(5'h0C, d); check("tick_write_wins", d, 32'h1234);

    repeat (600) begin
      bus_addr = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 4) * 4);
      bus_we = $urandom_range(0, 3) == 0;
      bus_re = $urandom_range(0, 1) == 1;
      bus_wdata = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 60) : $urandom;
      if ($urandom_range(0, 7) == 0) ext_irq = ~ext_irq;
      mie_global = $urandom_range(0, 7) != 0;
      mie_mask = 3'($urandom);
      irq_ack = $urandom_range(0, 3) == 0;
      mret = $urandom_range(0, 5) == 0;
      tick();
    end
    bus_we = 0; bus_re = 0; ext_irq = 0; irq_ack = 0; mie_global = 0; mie_mask = 0;

    mret = 1; tick(); mret = 0; tick();
    wr(5'h00, 1);
    mie_mask = 3'b001; mie_global = 1;
    tick();
    check("pre_rst_req", interrupt, 1);
    #2 rst = 0;
    #1 check("async_rst_int", interrupt, 0);
    check("async_rst_cause", irq_cause, 0);
    mreset();
    @(negedge clk);
    rst = 1;
    tick();
    check("post_rst_int", interrupt, 0);
    rd(5'h00, d); check("post_rst_msip", d, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
